// File: rtl/key_operand_entry.sv
// key_operand_entry: synchronised, debounced push-button front end owning operands a/b and opcode op.
// Auto-repeat on KEY[2:0] is built only when the AUTO_REPEAT_EN macro is defined.
module key_operand_entry #(
    parameter int unsigned DB_CYCLES  = 500000,
    parameter int unsigned MAX_DIGIT  = 9,
    parameter int unsigned REPEAT_DLY = 25000000,
    parameter int unsigned REPEAT_PER = 10000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [3:0] KEY,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [1:0] op,
    output logic [3:0] key_pulse
);
    localparam int unsigned   CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [3:0]    MAX_D   = 4'(MAX_DIGIT);

    logic [3:0]    s1, s2, st;
    logic [CW-1:0] cnt [4];
    logic [3:0]    flip, press, act;

    // A flip happens on the DB_CYCLES-th consecutive disagreeing edge; a press is a flip away from released.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        flip  = '0;
        press = '0;
        for (int i = 0; i < 4; i++) begin
            flip[i]  = (s2[i] != st[i]) && (cnt[i] == DB_LAST);
            press[i] = flip[i] && st[i];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            s1 <= 4'hF;
            s2 <= 4'hF;
            st <= 4'hF;
            // NOTE: the counter array is plain flops, not RAM, so it is cleared explicitly in reset.
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            s1 <= KEY;
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                if ((s2[i] == st[i]) || flip[i]) cnt[i] <= '0;
                else                             cnt[i] <= cnt[i] + CW'(1);
                if (flip[i]) st[i] <= ~st[i];
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned   RW         = $clog2(REPEAT_DLY + 1);
    localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DLY - REPEAT_PER);

    logic [RW-1:0] rep [3];
    logic [2:0]    rep_en, fire;

    always_comb begin
        fire = '0;
        for (int i = 0; i < 3; i++)
            fire[i] = rep_en[i] && !st[i] && (rep[i] == REP_LAST);
    end

    // Reloading to DLY-PER after a fire makes later repeats land every REPEAT_PER cycles.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N || press[3]) begin
            rep_en <= '0;
            for (int i = 0; i < 3; i++) rep[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (press[i]) begin
                    rep[i]    <= '0;
                    rep_en[i] <= 1'b1;
                end else if (st[i] || !rep_en[i]) begin
                    rep[i] <= '0;
                end else if (fire[i]) begin
                    rep[i] <= REP_RELOAD;
                end else begin
                    rep[i] <= rep[i] + RW'(1);
                end
            end
        end
    end

    assign act = {press[3], press[2:0] | fire};
`else
    // Repeat timing has no hardware in this build; the block only anchors the parameters.
    if ((REPEAT_DLY == 0) || (REPEAT_PER == 0)) begin : g_no_repeat
    end

    assign act = press;
`endif

    function automatic logic [3:0] step_digit(input logic [3:0] v);
        return (v >= MAX_D) ? 4'd0 : v + 4'd1;
    endfunction

    // Clear overrides any step in the same cycle; all accepted actions still strobe.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            a         <= '0;
            b         <= '0;
            op        <= '0;
            key_pulse <= '0;
        end else begin
            key_pulse <= act;
            if (act[3]) begin
                a  <= '0;
                b  <= '0;
                op <= '0;
            end else begin
                if (act[2]) a  <= step_digit(a);
                if (act[1]) b  <= step_digit(b);
                if (act[0]) op <= op + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_operand_entry.sv
// Scoreboard bench for key_operand_entry: expected strobes and register values are queued at
// stimulus time and retired when key_pulse fires. Honours AUTO_REPEAT_EN like the design.
module tb_key_operand_entry;
    localparam int DB   = 4;
    localparam int MAXD = 9;
    localparam int RDLY = 20;
    localparam int RPER = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key   = 4'hF;
    logic [3:0] a, b, key_pulse;
    logic [1:0] op;

    key_operand_entry #(
        .DB_CYCLES (DB),
        .MAX_DIGIT (MAXD),
        .REPEAT_DLY(RDLY),
        .REPEAT_PER(RPER)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .KEY      (key),
        .a        (a),
        .b        (b),
        .op       (op),
        .key_pulse(key_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [3:0] pulse;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] m_a   = 4'd0;
    logic [3:0] m_b   = 4'd0;
    logic [1:0] m_op  = 2'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference action model, applied in event order.
    function automatic void post(input logic [3:0] m, input int t);
        if (m[3]) begin
            m_a  = 4'd0;
            m_b  = 4'd0;
            m_op = 2'd0;
        end else begin
            if (m[2]) m_a = (m_a >= 4'(MAXD)) ? 4'd0 : m_a + 4'd1;
            if (m[1]) m_b = (m_b >= 4'(MAXD)) ? 4'd0 : m_b + 4'd1;
            if (m[0]) m_op = m_op + 2'd1;
        end
        sb.push_back(exp_t'{t, m, m_a, m_b, m_op});
    endfunction

    // Retire queued events: a strobe must match the head entry at exactly its cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].t < cyc) begin
            check("missed_pulse_cycle", 32'(cyc), 32'(sb[0].t));
            void'(sb.pop_front());
        end
        if (key_pulse !== 4'h0) begin
            if (sb.size() == 0 || sb[0].t != cyc) begin
                check("unexpected_pulse", 32'(key_pulse), 32'h0);
            end else begin
                e = sb.pop_front();
                check("key_pulse", 32'(key_pulse), 32'(e.pulse));
                check("a_at_event", 32'(a), 32'(e.a));
                check("b_at_event", 32'(b), 32'(e.b));
                check("op_at_event", 32'(op), 32'(e.op));
            end
        end
    end

    // Hold the masked keys low for 'hold' cycles from the next edge, then release and settle.
    task automatic press(input logic [3:0] mask, input int hold);
        int e0;
        e0  = cyc + 1;
        key = ~mask;
        if (hold >= DB) begin
            post(mask, e0 + DB + 1);
`ifdef AUTO_REPEAT_EN
            if (!mask[3] && mask[2:0] != 3'b000)
                for (int t = e0 + DB + 1 + RDLY; t <= e0 + hold + DB + 1; t += RPER)
                    post(mask & 4'b0111, t);
`endif
        end
        repeat (hold) @(negedge clk);
        key = 4'hF;
        repeat (DB + 8) @(negedge clk);
    endtask

    initial begin
        int e0;

        // Reset state with keys released.
        repeat (3) @(negedge clk);
        check("rst_a", 32'(a), 32'h0);
        check("rst_b", 32'(b), 32'h0);
        check("rst_op", 32'(op), 32'h0);
        check("rst_pulse", 32'(key_pulse), 32'h0);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_pulse", 32'(key_pulse), 32'h0);
        end
        check("idle_a", 32'(a), 32'h0);

        // Long hold on KEY[2]: one step (plus repeats when built in).
        press(4'b0100, 30);
        check("a_after_hold", 32'(a), 32'(m_a));

        // A 3-cycle glitch is rejected.
        press(4'b0010, 3);
        check("b_after_glitch", 32'(b), 32'h0);

        // Valid KEY[1] press with a 1-0-1 release bounce steps once.
        e0  = cyc + 1;
        key = 4'b1101;
        post(4'b0010, e0 + DB + 1);
        repeat (8) @(negedge clk);
        key = 4'hF;
        @(negedge clk);
        key = 4'b1101;
        @(negedge clk);
        key = 4'hF;
        repeat (16) @(negedge clk);
        check("b_after_bounce", 32'(b), 32'h1);

        // Simultaneous a/b/op steps all apply.
        press(4'b0111, 6);

        // Clear, then walk a through its wrap and op through its wrap.
        press(4'b1000, 6);
        check("clr_a", 32'(a), 32'h0);
        check("clr_b", 32'(b), 32'h0);
        check("clr_op", 32'(op), 32'h0);
        for (int i = 0; i < 10; i++) begin
            press(4'b0100, 6);
            check("a_walk", 32'(a), 32'((i + 1) % 10));
        end
        for (int i = 0; i < 5; i++) begin
            press(4'b0001, 6);
            check("op_walk", 32'(op), 32'((i + 1) % 4));
        end
        for (int i = 0; i < 5; i++) press(4'b0100, 6);
        check("a_preset", 32'(a), 32'h5);

        // Clear and step on the same edge: clear wins, both strobes assert.
        press(4'b1100, 6);
        check("clr_win_a", 32'(a), 32'h0);
        check("clr_win_op", 32'(op), 32'h0);

        // KEY[1] held through a one-cycle reset: the press is re-accepted after reset.
        e0  = cyc + 1;
        key = 4'b1101;
        post(4'b0010, e0 + DB + 1);
`ifdef AUTO_REPEAT_EN
        post(4'b0010, e0 + DB + 1 + RDLY);
`endif
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_a", 32'(a), 32'h0);
        check("midrst_b", 32'(b), 32'h0);
        check("midrst_pulse", 32'(key_pulse), 32'h0);
        m_a  = 4'd0;
        m_b  = 4'd0;
        m_op = 2'd0;
        post(4'b0010, e0 + 31 + DB + 1);
        repeat (4) @(negedge clk);
        check("b_no_repeat_after_rst", 32'(b), 32'h0);
        repeat (10) @(negedge clk);
        key = 4'hF;
        repeat (DB + 8) @(negedge clk);
        check("b_repressed", 32'(b), 32'h1);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
